// File: rtl/cart_loader_pkg.sv
// Shared types and constants for the cartridge/BIOS download loader.
package cart_loader_pkg;

  localparam logic [15:0] BIOS_BASE = 16'hE000;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ
  } state_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } fifo_entry_t;

  // BIOS images occupy the top 8 KiB; cart images map straight through.
  function automatic logic [15:0] map_addr(input logic is_cart, input logic [15:0] addr);
    logic [15:0] m;
    m = addr;
    if (!is_cart) m[15:13] = BIOS_BASE[15:13];
    return m;
  endfunction

endpackage

// File: rtl/cart_loader_fifo.sv
// Write buffer between the download port and SDRAM; pointers carry one extra wrap bit.
module cart_loader_fifo
  import cart_loader_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        push,
  input  fifo_entry_t din,
  input  logic        pop,
  output fifo_entry_t dout,
  output logic        full,
  output logic        empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  fifo_entry_t mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      mem    <= '{default: '0};
    end else begin
      if (push && !full) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/cart_loader.sv
// Download-to-SDRAM loader with core-reset and logo-skip timers.
// Optional byte checksum on cart_sum when CART_LOADER_CHECKSUM_EN is defined.
module cart_loader
  import cart_loader_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned RESET_CYCLES = 1000,
  parameter int unsigned SKIP_DELAY   = 5000000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        cart_rd,
  input  logic [15:0] cart_addr,
  input  logic        user_reset,
  input  logic        skip_logo,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        mem_we,
  output logic        mem_rd,
  input  logic        mem_ack,
  output logic        core_reset,
  output logic        overflow,
  output logic [15:0] cart_sum
);

  localparam logic [15:0] RST_LOAD  = 16'(RESET_CYCLES);
  localparam logic [31:0] SKIP_LOAD = 32'(SKIP_DELAY);

  fifo_entry_t fifo_in;
  fifo_entry_t head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic        drop;
  logic        download_q;
  logic        dl_rise;
  logic        skip_load;
  logic        skip_pulse;
  logic        reset_start;
  logic [15:0] rst_cnt;
  logic [31:0] skip_cnt;
  state_t      state;
  logic        unused_bits;

  assign unused_bits = ^{ioctl_index[7:1], ioctl_addr[24:16]};

  assign push      = ioctl_download & ioctl_wr;
  assign drop      = push & fifo_full;
  assign pop       = (state == WRITE) & mem_ack;
  assign dl_rise   = ioctl_download & ~download_q;
  assign skip_load = ioctl_download & skip_logo;
  assign fifo_in   = '{addr: map_addr(ioctl_index[0], ioctl_addr[15:0]), data: ioctl_dout};

  cart_loader_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_sys(clk_sys),
    .reset  (reset),
    .push   (push),
    .din    (fifo_in),
    .pop    (pop),
    .dout   (head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Writes always win; reads only start once the download is over and the buffer is dry.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= IDLE;
      mem_addr <= '0;
      mem_din  <= '0;
      mem_we   <= 1'b0;
      mem_rd   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state    <= WRITE;
            mem_addr <= head.addr;
            mem_din  <= head.data;
            mem_we   <= 1'b1;
          end else if (!ioctl_download && cart_rd) begin
            state    <= READ;
            mem_addr <= cart_addr;
            mem_rd   <= 1'b1;
          end
        end
        WRITE: begin
          if (mem_ack) begin
            state  <= IDLE;
            mem_we <= 1'b0;
          end
        end
        READ: begin
          if (mem_ack) begin
            state  <= IDLE;
            mem_rd <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          mem_we <= 1'b0;
          mem_rd <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      download_q  <= 1'b0;
      overflow    <= 1'b0;
      reset_start <= 1'b0;
      rst_cnt     <= '0;
      skip_cnt    <= '0;
      skip_pulse  <= 1'b0;
    end else begin
      download_q <= ioctl_download;
      if (dl_rise) overflow <= 1'b0;
      if (drop) overflow <= 1'b1;
      reset_start <= user_reset | ioctl_download | skip_pulse | ~fifo_empty;
      if (reset_start) rst_cnt <= RST_LOAD;
      else if (rst_cnt != '0) rst_cnt <= rst_cnt - 16'd1;
      if (skip_load) skip_cnt <= SKIP_LOAD;
      else if (skip_cnt != '0) skip_cnt <= skip_cnt - 32'd1;
      skip_pulse <= ~skip_load & (skip_cnt == 32'd1);
    end
  end

  assign core_reset = (rst_cnt != '0);

`ifdef CART_LOADER_CHECKSUM_EN
  logic [15:0] sum_q;

  always_ff @(posedge clk_sys) begin
    if (reset) sum_q <= '0;
    else if (dl_rise) sum_q <= '0;
    else if (pop) sum_q <= sum_q + {8'h00, head.data};
  end

  assign cart_sum = sum_q;
`else
  assign cart_sum = '0;
`endif

endmodule

// File: doc/cart_loader.md
CART_LOADER -- requirements
Module: cart_loader

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: write-buffer entries; power of two, 2..16.
REQ-002 Parameter RESET_CYCLES, default 1000: core-reset hold length in clocks.
REQ-003 Parameter SKIP_DELAY, default 5000000: clocks from last download activity to the logo-skip reset.
REQ-004 Ports:
- clk_sys  in  1: sole clock.
- reset  in  1: synchronous, active-high.
- ioctl_download  in  1: download in progress.
- ioctl_index  in  8: image index; bit0=0 is BIOS, bit0=1 is cart.
- ioctl_wr  in  1: byte strobe, one clock.
- ioctl_addr  in  25: byte address.
- ioctl_dout  in  8: byte data.
- cart_rd  in  1: core read request.
- cart_addr  in  16: core read address.
- user_reset  in  1: OSD or button reset request.
- skip_logo  in  1: logo-skip reset enabled.
- mem_addr  out  16: SDRAM address.
- mem_din  out  8: SDRAM write data.
- mem_we  out  1: SDRAM write request.
- mem_rd  out  1: SDRAM read request.
- mem_ack  in  1: one-clock SDRAM completion.
- core_reset  out  1: reset to the console core.
- overflow  out  1: sticky, byte dropped.
- cart_sum  out  16: byte checksum (see REQ-019).

Function
REQ-005 Address map: index bit0=0 gives {3'b111, ioctl_addr[12:0]} (BIOS at 0xE000-0xFFFF); bit0=1 gives ioctl_addr[15:0]; upper ioctl_addr bits are ignored.
REQ-006 Push: ioctl_download&ioctl_wr with FIFO not full pushes {mapped addr, dout} in the same clock.
REQ-007 Full: a strobe arriving when the FIFO is full drops the byte and sets overflow; overflow clears only on reset or on a 0->1 edge of ioctl_download.
REQ-008 FSM states: IDLE, WRITE, READ.
- IDLE: FIFO non-empty goes to WRITE (head driven, mem_we=1).
- IDLE: FIFO empty, ioctl_download=0 and cart_rd=1 goes to READ (mem_addr=cart_addr, mem_rd=1).
- WRITE/READ: hold outputs stable until mem_ack, then pop (WRITE only) and return to IDLE.
REQ-009 Priority: writes beat reads; cart_rd is ignored while downloading or while the FIFO is non-empty.
REQ-010 Latency: a byte pushed into an empty FIFO while in IDLE raises mem_we two clocks after the strobe.
REQ-011 Simultaneous push and pop in one clock is legal; occupancy is unchanged.
REQ-012 FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH.
REQ-013 reset_start is registered: user_reset | ioctl_download | skip_pulse | FIFO non-empty.
REQ-014 Reset counter (16-bit) loads RESET_CYCLES on every clock reset_start=1 and otherwise decrements to 0; core_reset=1 while the counter is non-zero.
REQ-015 Skip timer (32-bit) loads SKIP_DELAY on every clock ioctl_download&skip_logo=1, otherwise decrements to 0.
REQ-016 skip_pulse is a one-clock pulse when the skip timer steps 1->0; a new download restarts the timer.

Reset
REQ-017 Reset zeroes the FIFO, both counters, overflow, cart_sum, mem_we, mem_rd and skip_pulse, and sets state to IDLE.
REQ-018 core_reset is 0 on the first clock after reset and asserts RESET_CYCLES-long once reset_start registers. Reset mid-WRITE abandons the write; any later mem_ack is ignored.

Configuration
REQ-019 Macro CART_LOADER_CHECKSUM_EN:
- Defined: cart_sum adds each byte as it leaves the FIFO (16-bit wrap) and clears on the 0->1 edge of ioctl_download.
- Undefined: cart_sum is tied to 0 and no adder is built.

Structure
REQ-020 Package cart_loader_pkg holds BIOS_BASE (16'hE000), the state enum, and the FIFO entry struct {addr[15:0], data[7:0]}.
REQ-021 The FIFO is sub-module cart_loader_fifo (parameterised depth, push/pop/full/empty); the FSM and timers stay in cart_loader.

Verification
REQ-022 Index 0, addr 0x0005, data 0xA5 -> single mem_we at mem_addr 0xE005, mem_din 0xA5, held until mem_ack.
REQ-023 Strobes every clock with mem_ack 6 clocks after mem_we, FIFO_DEPTH 4 -> overflow=1 at the fifth outstanding byte; already-accepted bytes are written in order.
REQ-024 cart_rd during a download with the FIFO draining -> no mem_rd until download=0 and the FIFO is empty; the read then uses cart_addr.
REQ-025 skip_logo=1, SKIP_DELAY=10, download ends -> skip_pulse 10 clocks later, then core_reset high for exactly 1000 clocks; with skip_logo=0 no second reset occurs.
REQ-026 Reset asserted mid-WRITE, then mem_ack -> mem_we=0, FIFO empty, no pop, state IDLE.
REQ-027 With CART_LOADER_CHECKSUM_EN, bytes 0xFF,0x02 -> cart_sum=0x0101; without the macro -> cart_sum=0.
